dmem_stream_reader: RTL

Bus reader on the read-only second port of the dual-port data memory, the port the processor leaves unused. On a start pulse it walks a block of consecutive 32-bit words, beginning at a base byte address, and streams them out over a valid/ready interface. Downstream consumers are a display or debug sink. It is the reader counterpart to the processor's store path: the CPU writes data memory, and this block drains it without disturbing port 0.

---
 rtl/dmem_reader_pkg.sv | 14 +
 rtl/dmem_stream_reader.sv | 114 +++++++++++
 2 files changed

// File: rtl/dmem_reader_pkg.sv
// Shared types and constants for the data-memory stream reader.
package dmem_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM,
        DONE
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_LSB   = 2;

endpackage

// File: rtl/dmem_stream_reader.sv
// Streams a block of consecutive words from the spare data-memory read port over valid/ready.
// Optional stall counter output enabled by defining DMEM_READER_STATS_EN.
module dmem_stream_reader
    import dmem_reader_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef DMEM_READER_STATS_EN
    output logic [15:0]       stall_cycles,
`endif
    output logic              out_last
);

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remaining;
    logic              handshake;

    assign mem_addr  = cur_addr;
    assign handshake = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            cur_addr  <= '0;
            remaining <= '0;
`ifdef DMEM_READER_STATS_EN
            stall_cycles <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
`ifdef DMEM_READER_STATS_EN
                        stall_cycles <= '0;
`endif
                        if (word_count != '0) begin
                            cur_addr  <= {base_addr[ADDR_W-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
                            remaining <= word_count;
                            state     <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                FETCH: begin
                    out_data  <= mem_rdata;
                    out_last  <= (remaining == CNT_W'(1));
                    cur_addr  <= cur_addr + ADDR_W'(WORD_BYTES);
                    remaining <= remaining - CNT_W'(1);
                    out_valid <= 1'b1;
                    state     <= STREAM;
                end

                STREAM: begin
                    if (handshake) begin
                        // Next word is captured on the accepting edge to keep 1 word/cycle.
                        if (remaining != '0) begin
                            out_data  <= mem_rdata;
                            out_last  <= (remaining == CNT_W'(1));
                            cur_addr  <= cur_addr + ADDR_W'(WORD_BYTES);
                            remaining <= remaining - CNT_W'(1);
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
`ifdef DMEM_READER_STATS_EN
                    else if (stall_cycles != 16'hFFFF) begin
                        stall_cycles <= stall_cycles + 16'd1;
                    end
`endif
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
